// File: rtl/param_load_sequencer.sv
// Byte-serial parameter load sequencer: turns host byte strobes into addressed
// single-cycle writes into the parameter bank and holds the network off meanwhile.
module param_load_sequencer #(
   parameter int NUM_PARAMS = 8,
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              load_params,
   input  logic              data_valid,
   input  logic [DATA_W-1:0] data_in,
   output logic              param_wr_en,
   output logic [ADDR_W-1:0] param_addr,
   output logic [DATA_W-1:0] param_wr_data,
   output logic              network_hold,
   output logic              busy,
   output logic              done,
   output logic              abort_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PARAMS - 1);

   state_t            state;
   logic [ADDR_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         count         <= '0;
         param_wr_en   <= 1'b0;
         param_addr    <= '0;
         param_wr_data <= '0;
         network_hold  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         abort_err     <= 1'b0;
      end else begin
         // The write pulse is single-cycle and never survives a frozen cycle.
         param_wr_en <= 1'b0;
         if (enable) begin
            case (state)
               IDLE: begin
                  if (load_params) begin
                     state        <= LOAD;
                     count        <= '0;
                     network_hold <= 1'b1;
                     busy         <= 1'b1;
                     done         <= 1'b0;
                     abort_err    <= 1'b0;
                  end
               end
               LOAD: begin
                  if (!load_params) begin
                     state        <= IDLE;
                     network_hold <= 1'b0;
                     busy         <= 1'b0;
                     abort_err    <= 1'b1;
                  end else if (data_valid) begin
                     param_wr_en   <= 1'b1;
                     param_addr    <= count;
                     param_wr_data <= data_in;
                     // Saturate at the last address so the counter never wraps.
                     if (count == LAST_ADDR) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        count <= count + ADDR_W'(1);
                     end
                  end
               end
               DONE: begin
                  if (!load_params) begin
                     state        <= IDLE;
                     done         <= 1'b0;
                     network_hold <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/param_load_sequencer.md
Name: param_load_sequencer

Overview:
Sequences a byte-serial parameter load into the RSNN parameter register bank (weights, thresholds, decay constants). Converts host byte strobes into addressed single-cycle write pulses and counts writes to completion. Holds the neuron update datapath off while a load is in progress. Sits between the host/pin interface and the parameter registers and replaces the single-pulse write control used for one-shot loads.

Parameters:
NUM_PARAMS, 8, number of parameter registers written per load (2..2^ADDR_W)
DATA_W, 8, parameter byte width
ADDR_W, 3, parameter address width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
enable  input  1  global clock-enable; when low, FSM and counters freeze
load_params  input  1  level; host requests/holds load mode
data_valid  input  1  one-cycle strobe; data_in carries a parameter byte
data_in  input  DATA_W  parameter byte
param_wr_en  output  1  one-cycle write pulse to parameter bank
param_addr  output  ADDR_W  target register address
param_wr_data  output  DATA_W  byte to write
network_hold  output  1  stalls neuron/state updates while high
busy  output  1  high in LOAD
done  output  1  high in DONE (full set written)
abort_err  output  1  sticky; load aborted before completion

Behaviour:
- Reset (async): state IDLE, write counter 0, all outputs 0.
- All outputs registered. Every state/counter/output update requires enable=1, except param_wr_en, which is forced to 0 on any cycle with enable=0. Other outputs hold their values while enable=0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - load_params=1 -> LOAD next cycle.
  - On entry to LOAD: counter=0, network_hold=1, busy=1, abort_err cleared.
  - data_valid is ignored in IDLE.
- LOAD:
  - data_valid=1 and load_params=1 in cycle n -> in cycle n+1: param_wr_en=1 for exactly one cycle, param_addr=counter, param_wr_data=data_in as sampled at n. Counter then increments.
  - One write per strobe; back-to-back strobes give back-to-back writes.
  - Strobe while counter=NUM_PARAMS-1: that write is issued, then -> DONE in the same cycle the write pulse appears. busy=0, done=1.
  - load_params=0 before the final write -> IDLE, abort_err=1, network_hold=0, busy=0. A strobe in that same cycle is discarded (no write). Registers already written keep their values.
- DONE:
  - done=1 and network_hold=1 until load_params=0.
  - load_params=0 -> IDLE; done=0 and network_hold=0 next cycle.
  - Further strobes in DONE are ignored; the counter never exceeds NUM_PARAMS-1 and never wraps.
- param_addr/param_wr_data hold their last values when param_wr_en=0.
- abort_err persists through IDLE and is cleared only by rst or the next LOAD entry.
- data_valid with enable=0: dropped, no write, counter unchanged.
- Reset mid-LOAD: immediate return to reset values; any pending write pulse is suppressed.

Test Plan:
- Full load: load_params=1, then 8 strobes data 0x10..0x17 one per cycle -> 8 wr pulses, addr 0..7 with matching data at 1-cycle latency; done=1 on the 8th pulse; network_hold=1 throughout. Drop load_params -> done=0, hold=0 next cycle.
- Abort: 3 strobes, then load_params=0 together with a 4th strobe -> only addr 0..2 written; abort_err=1; state IDLE. Next load_params=1 -> abort_err cleared.
- Enable gating: enable=0 during LOAD for 4 cycles with 2 strobes -> no pulses, counter frozen. Re-enable, 8 strobes -> addr 0..7 written, done=1.
- Extra strobes: 10 strobes with load_params held -> exactly 8 pulses; strobes 9-10 ignored; param_addr stays 7.
- Async reset after the 5th write -> all outputs 0 immediately. New load restarts at addr 0.
- Idle noise: strobes with load_params=0 -> no param_wr_en, busy=0, network_hold=0.
